fp_cmd_issuer: RTL and testbench

FP_CMD_ISSUER -- requirements
Module: fp_cmd_issuer

---
 rtl/fp_cmd_issuer.sv | 178 +++++++++++++++++
 tb/tb_fp_cmd_issuer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_cmd_issuer.sv
// Fixed-point command issuer: queues Add/Mul/Div commands and issues them one at a time to an arithmetic core.
// Latency: push at edge N -> core_start in cycle N+1..N+2 -> out_valid from edge N+3 (Add/Mul); Div waits for core_done.
// Backpressure: in_ready drops when the FIFO is full; results are held until out_ready. Optional macro FP_ISSUE_TIMEOUT_EN adds a Div watchdog.
module fp_cmd_issuer #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 4,
    parameter int DIV_TMO = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_opcode,
    output logic [WIDTH-1:0] core_a,
    output logic [WIDTH-1:0] core_b,
    output logic [1:0]       core_opcode,
    output logic             core_start,
    input  logic [WIDTH-1:0] core_c,
    input  logic             core_done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [1:0]       out_opcode,
    output logic             out_err
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [1:0] OP_DIV = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

    state_t r_state, w_nxt_state;

    logic [WIDTH-1:0] r_mem_a  [DEPTH];
    logic [WIDTH-1:0] r_mem_b  [DEPTH];
    logic [1:0]       r_mem_op [DEPTH];
    logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic [WIDTH-1:0] r_op_a, r_op_b, r_result;
    logic [1:0]       r_op_code, r_res_op;
    logic             r_err;

    logic             w_push, w_pop, w_capture, w_cap_err;
    logic [WIDTH-1:0] w_cap_val;
    logic [1:0]       w_cap_op, w_head_op;
    logic             w_tmo_hit;

    assign in_ready  = (r_count != CW'(DEPTH));
    assign w_push    = in_valid && in_ready;
    assign w_head_op = r_mem_op[r_rd_ptr];

`ifdef FP_ISSUE_TIMEOUT_EN
    localparam int TW = $clog2(DIV_TMO + 1);
    logic [TW-1:0] r_tmo_cnt;

    // Count cycles spent in WAIT; cleared whenever the FSM is elsewhere.
    always_ff @(posedge clk) begin
        if (rst || r_state != S_WAIT) r_tmo_cnt <= '0;
        else                          r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end

    assign w_tmo_hit = (r_op_code == OP_DIV) && (r_tmo_cnt == TW'(DIV_TMO - 1));
`else
    // Without the watchdog a Div waits for core_done indefinitely.
    logic w_unused_tmo;
    assign w_unused_tmo = (DIV_TMO > 0);
    assign w_tmo_hit    = 1'b0;
`endif

    // FIFO storage: entries are invalidated by the pointers, so no reset is needed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr]  <= in_a;
            r_mem_b[r_wr_ptr]  <= in_b;
            r_mem_op[r_wr_ptr] <= in_opcode;
        end
    end

    // FIFO pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_nxt_state;
    end

    // Next-state and capture decisions; illegal opcodes bypass the core entirely.
    always_comb begin
        w_nxt_state = r_state;
        w_pop       = 1'b0;
        w_capture   = 1'b0;
        w_cap_val   = '0;
        w_cap_err   = 1'b0;
        w_cap_op    = r_op_code;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_pop = 1'b1;
                    if (w_head_op == OP_ILL) begin
                        w_capture   = 1'b1;
                        w_cap_val   = '1;
                        w_cap_err   = 1'b1;
                        w_cap_op    = w_head_op;
                        w_nxt_state = S_HOLD;
                    end else begin
                        w_nxt_state = S_ISSUE;
                    end
                end
            end
            S_ISSUE: w_nxt_state = S_WAIT;
            S_WAIT: begin
                if (r_op_code != OP_DIV || core_done) begin
                    w_capture   = 1'b1;
                    w_cap_val   = core_c;
                    w_nxt_state = S_HOLD;
                end else if (w_tmo_hit) begin
                    w_capture   = 1'b1;
                    w_cap_err   = 1'b1;
                    w_nxt_state = S_HOLD;
                end
            end
            S_HOLD: if (out_ready) w_nxt_state = S_IDLE;
            default: w_nxt_state = S_IDLE;
        endcase
    end

    // Operand and result registers: operands load on pop and stay put through WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_op_code <= '0;
            r_result  <= '0;
            r_res_op  <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_pop) begin
                r_op_a    <= r_mem_a[r_rd_ptr];
                r_op_b    <= r_mem_b[r_rd_ptr];
                r_op_code <= w_head_op;
            end
            if (w_capture) begin
                r_result <= w_cap_val;
                r_res_op <= w_cap_op;
                r_err    <= w_cap_err;
            end
        end
    end

    // Outputs are forced quiet while reset is held, not just after the reset edge.
    assign core_start  = (r_state == S_ISSUE) && !rst;
    assign out_valid   = (r_state == S_HOLD) && !rst;
    assign core_a      = rst ? '0 : r_op_a;
    assign core_b      = rst ? '0 : r_op_b;
    assign core_opcode = r_op_code;
    assign out_result  = rst ? '0 : r_result;
    assign out_err     = r_err && !rst;
    assign out_opcode  = r_res_op;
endmodule

// File: tb/tb_fp_cmd_issuer.sv
module tb_fp_cmd_issuer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0, in_b = '0;
    logic [1:0]  in_opcode = '0;
    logic [31:0] core_a, core_b, core_c;
    logic [1:0]  core_opcode;
    logic        core_start, core_done;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic [1:0]  out_opcode;
    logic        out_err;

    logic        done_resp = 1'b0;
    logic        done_spur = 1'b0;
    assign core_done = done_resp | done_spur;

    int          n_chk = 0;
    int          n_fail = 0;
    int          start_cnt = 0;
    bit          div_never = 1'b0;
    int          div_delay = 3;
    logic [34:0] exp_q[$];

    fp_cmd_issuer #(.WIDTH(32), .DEPTH(4), .DIV_TMO(64)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_opcode(in_opcode),
        .core_a(core_a), .core_b(core_b), .core_opcode(core_opcode),
        .core_start(core_start), .core_c(core_c), .core_done(core_done),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_opcode(out_opcode), .out_err(out_err)
    );

    always #5 clk = ~clk;

    // Behavioural Q8.23 arithmetic core.
    function automatic logic [31:0] fx(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        longint sa, sb, p;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        p  = 0;
        case (op)
            2'b00:   p = sa + sb;
            2'b01:   p = (sa * sb) >>> 23;
            2'b10:   p = (sb != 0) ? ((sa <<< 23) / sb) : 0;
            default: p = 0;
        endcase
        return p[31:0];
    endfunction

    always_comb core_c = fx(core_a, core_b, core_opcode);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    always @(posedge clk) if (core_start) start_cnt++;

    // Monitor: compares every accepted result against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_result: got %h op %b err %b, expected none", out_result, out_opcode, out_err);
            end else begin
                logic [34:0] e;
                e = exp_q.pop_front();
                chk("out_result", out_result, e[34:3]);
                chk("out_opcode", {30'd0, out_opcode}, {30'd0, e[2:1]});
                chk("out_err", {31'd0, out_err}, {31'd0, e[0]});
            end
        end
    end

    // Divide responder: raises core_done div_delay cycles after core_start, checks operand stability.
    initial begin
        forever begin
            @(negedge clk);
            if (core_start && core_opcode == 2'b10 && !div_never) begin
                logic [31:0] a0, b0;
                bit          aborted;
                a0 = core_a;
                b0 = core_b;
                aborted = 1'b0;
                for (int i = 0; i < div_delay && !aborted; i++) begin
                    @(negedge clk);
                    if (rst) aborted = 1'b1;
                end
                if (!aborted) begin
                    chk("div_wait_no_valid", {31'd0, out_valid}, 32'd0);
                    chk("div_core_a_stable", core_a, a0);
                    chk("div_core_b_stable", core_b, b0);
                    done_resp = 1'b1;
                    @(negedge clk);
                    done_resp = 1'b0;
                    chk("div_captured_on_done", {31'd0, out_valid}, 32'd1);
                end
            end
        end
    end

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                        input logic [31:0] res, input logic err, input bit track);
        bit ok;
        ok = 1'b0;
        in_a = a;
        in_b = b;
        in_opcode = op;
        in_valid = 1'b1;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            @(posedge clk);
        end
        #1 in_valid = 1'b0;
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL push_timeout: got in_ready 0, expected 1");
        end else if (track) begin
            exp_q.push_back({res, op, err});
        end
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain_pending", exp_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int s;
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_core_start", {31'd0, core_start}, 32'd0);
        chk("rst_out_err", {31'd0, out_err}, 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_core_a", core_a, 32'd0);
        chk("rst_core_b", core_b, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1 out_ready = 1'b1;

        // Add latency: 1.5 + 2.25 = 3.75
        push(32'h00C00000, 32'h01200000, 2'b00, 32'h01E00000, 1'b0, 1'b1);
        @(negedge clk);
        chk("lat_no_start_n0", {31'd0, core_start}, 32'd0);
        @(negedge clk);
        chk("lat_start_n1", {31'd0, core_start}, 32'd1);
        chk("lat_core_a", core_a, 32'h00C00000);
        chk("lat_core_b", core_b, 32'h01200000);
        @(negedge clk);
        chk("lat_start_pulse_once", {31'd0, core_start}, 32'd0);
        chk("lat_no_valid_n2", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("lat_valid_n3", {31'd0, out_valid}, 32'd1);
        wait_drain(50);

        // Stray core_done while idle must not produce anything
        s = start_cnt;
        done_spur = 1'b1;
        @(posedge clk);
        #1 done_spur = 1'b0;
        @(negedge clk);
        chk("spur_done_no_valid", {31'd0, out_valid}, 32'd0);
        chk("spur_done_no_start", start_cnt, s);

        // Fill with out_ready low: five accepted, FIFO full, then drain in order
        @(posedge clk);
        #1 out_ready = 1'b0;
        push(32'h00C00000, 32'h01200000, 2'b00, 32'h01E00000, 1'b0, 1'b1);
        push(32'h01000000, 32'h00C00000, 2'b01, 32'h01800000, 1'b0, 1'b1);
        push(32'hFF800000, 32'h00400000, 2'b00, 32'hFFC00000, 1'b0, 1'b1);
        push(32'h01800000, 32'h00C00000, 2'b10, 32'h01000000, 1'b0, 1'b1);
        push(32'h00400000, 32'h00400000, 2'b01, 32'h00200000, 1'b0, 1'b1);
        @(negedge clk);
        chk("fifo_full_in_ready", {31'd0, in_ready}, 32'd0);
        repeat (3) @(negedge clk);
        chk("fifo_full_held", {31'd0, in_ready}, 32'd0);
        chk("fifo_full_result_held", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_drain(200);

        // Slow divide: 3.0 / 1.5 = 2.0, done 20 cycles after start
        div_delay = 20;
        push(32'h01800000, 32'h00C00000, 2'b10, 32'h01000000, 1'b0, 1'b1);
        wait_drain(200);
        div_delay = 3;

        // Illegal opcode: saturated result, error, no core issue
        s = start_cnt;
        push(32'h12345678, 32'h00000009, 2'b11, 32'hFFFFFFFF, 1'b1, 1'b1);
        wait_drain(50);
        chk("illegal_no_start", start_cnt, s);

`ifdef FP_ISSUE_TIMEOUT_EN
        // Watchdog: divide with no core_done ends in error
        div_never = 1'b1;
        push(32'h01800000, 32'h00C00000, 2'b10, 32'h00000000, 1'b1, 1'b1);
        wait_drain(300);
        div_never = 1'b0;
`endif

        // Reset mid-divide with three entries queued abandons everything
        div_never = 1'b1;
        push(32'h01800000, 32'h00C00000, 2'b10, 32'h0, 1'b0, 1'b0);
        push(32'h00800000, 32'h00800000, 2'b00, 32'h0, 1'b0, 1'b0);
        push(32'h00800000, 32'h00800000, 2'b00, 32'h0, 1'b0, 1'b0);
        push(32'h00800000, 32'h00800000, 2'b00, 32'h0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_core_a", core_a, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        div_never = 1'b0;
        s = start_cnt;
        @(negedge clk);
        chk("postrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("postrst_out_valid", {31'd0, out_valid}, 32'd0);
        repeat (20) @(negedge clk);
        chk("postrst_no_issue", start_cnt, s);
        chk("postrst_no_stale", {31'd0, out_valid}, 32'd0);

        // Block still works after reset
        push(32'h00800000, 32'h00800000, 2'b00, 32'h01000000, 1'b0, 1'b1);
        wait_drain(50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
